sonar_tx_scheduler: RTL and testbench

SONAR_TX_SCHEDULER -- requirements
Module: sonar_tx_scheduler

---
 rtl/sonar_tx_scheduler.sv | 142 ++++++++++++++
 tb/tb_sonar_tx_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_tx_scheduler.sv
// Sonar measurement frame scheduler.
// Sends one 8-character ASCII frame "AAA,DDD#" (servo angle and distance,
// three BCD digits each) to a serial transmitter, one character at a time.
// The scheduler starts each character with tx_partida and waits for
// tx_pronto. Digits are captured once at frame start, so the frame is
// consistent even if the inputs change while it is being sent. A frame is
// aborted with an erro pulse when the transmitter does not answer within
// TIMEOUT_CICLOS cycles.
module sonar_tx_scheduler #(
  parameter int TIMEOUT_CICLOS = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       transmitir,
  input  logic [3:0] angulo_centena,
  input  logic [3:0] angulo_dezena,
  input  logic [3:0] angulo_unidade,
  input  logic [3:0] distancia_centena,
  input  logic [3:0] distancia_dezena,
  input  logic [3:0] distancia_unidade,
  input  logic       tx_pronto,
  output logic       tx_partida,
  output logic [6:0] tx_dados,
  output logic       envio_pronto,
  output logic       erro,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  // The counter only has to hold values up to TIMEOUT_CICLOS-1.
  localparam int CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    PREPARA   = 4'h1,
    TRANSMITE = 4'h2,
    ESPERA    = 4'h3,
    PROXIMO   = 4'h4,
    FIM       = 4'h5,
    ERRO      = 4'hF
  } state_t;

  state_t           state;
  logic [2:0]       index;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cap_ang_c, cap_ang_d, cap_ang_u;
  logic [3:0]       cap_dist_c, cap_dist_d, cap_dist_u;

  // A non-BCD digit is shown as '?' so a corrupt reading is visible at the receiver.
  function automatic logic [6:0] digit_char(input logic [3:0] d);
    if (d <= 4'd9) return 7'h30 + {3'b000, d};
    else           return 7'h3F;
  endfunction

  // Character for the current index, built from the captured digits only.
  always_comb begin
    tx_dados = 7'h30;
    case (index)
      3'd0: tx_dados = digit_char(cap_ang_c);
      3'd1: tx_dados = digit_char(cap_ang_d);
      3'd2: tx_dados = digit_char(cap_ang_u);
      3'd3: tx_dados = 7'h2C;
      3'd4: tx_dados = digit_char(cap_dist_c);
      3'd5: tx_dados = digit_char(cap_dist_d);
      3'd6: tx_dados = digit_char(cap_dist_u);
      3'd7: tx_dados = 7'h23;
      default: tx_dados = 7'h30;
    endcase
  end

  assign ocupado   = (state != INICIAL);
  assign db_estado = state;

  // Frame FSM. The pulse outputs are registered on entry to the state that owns them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= INICIAL;
      index        <= 3'd0;
      cnt          <= '0;
      cap_ang_c    <= 4'd0;
      cap_ang_d    <= 4'd0;
      cap_ang_u    <= 4'd0;
      cap_dist_c   <= 4'd0;
      cap_dist_d   <= 4'd0;
      cap_dist_u   <= 4'd0;
      tx_partida   <= 1'b0;
      envio_pronto <= 1'b0;
      erro         <= 1'b0;
    end else begin
      tx_partida   <= 1'b0;
      envio_pronto <= 1'b0;
      erro         <= 1'b0;
      case (state)
        INICIAL: begin
          if (transmitir) begin
            cap_ang_c  <= angulo_centena;
            cap_ang_d  <= angulo_dezena;
            cap_ang_u  <= angulo_unidade;
            cap_dist_c <= distancia_centena;
            cap_dist_d <= distancia_dezena;
            cap_dist_u <= distancia_unidade;
            index      <= 3'd0;
            state      <= PREPARA;
          end
        end
        PREPARA: begin
          tx_partida <= 1'b1;
          state      <= TRANSMITE;
        end
        TRANSMITE: begin
          cnt   <= '0;
          state <= ESPERA;
        end
        ESPERA: begin
          // A character completing on the last allowed cycle still counts.
          if (tx_pronto) begin
            state <= PROXIMO;
          end else if (cnt == CNT_LAST) begin
            erro  <= 1'b1;
            state <= ERRO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PROXIMO: begin
          if (index == 3'd7) begin
            envio_pronto <= 1'b1;
            state        <= FIM;
          end else begin
            index <= index + 3'd1;
            state <= PREPARA;
          end
        end
        FIM:     state <= INICIAL;
        ERRO:    state <= INICIAL;
        default: state <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_tx_scheduler.sv
// Directed bench for sonar_tx_scheduler: frame content, latency, digit
// capture, timeout abort, timeout/tx_pronto race and mid-frame reset.
module tb_sonar_tx_scheduler;

  logic       clock;
  logic       reset;
  logic       transmitir;
  logic [3:0] angulo_centena, angulo_dezena, angulo_unidade;
  logic [3:0] distancia_centena, distancia_dezena, distancia_unidade;
  logic       tx_pronto;
  logic       tx_partida, envio_pronto, erro, ocupado;
  logic [6:0] tx_dados;
  logic [3:0] db_estado;

  logic       t_partida, t_envio, t_erro, t_ocupado;
  logic [6:0] t_dados;
  logic [3:0] t_db;

  int checks = 0;
  int errors = 0;

  logic [6:0] chars [8];
  int         part_cyc [8];
  int         nchars, nenv, nerr, env_cyc;
  logic       done;

  sonar_tx_scheduler dut (
    .clock(clock), .reset(reset), .transmitir(transmitir),
    .angulo_centena(angulo_centena), .angulo_dezena(angulo_dezena),
    .angulo_unidade(angulo_unidade), .distancia_centena(distancia_centena),
    .distancia_dezena(distancia_dezena), .distancia_unidade(distancia_unidade),
    .tx_pronto(tx_pronto), .tx_partida(tx_partida), .tx_dados(tx_dados),
    .envio_pronto(envio_pronto), .erro(erro), .ocupado(ocupado),
    .db_estado(db_estado)
  );

  sonar_tx_scheduler #(.TIMEOUT_CICLOS(16)) dut_t (
    .clock(clock), .reset(reset), .transmitir(transmitir),
    .angulo_centena(angulo_centena), .angulo_dezena(angulo_dezena),
    .angulo_unidade(angulo_unidade), .distancia_centena(distancia_centena),
    .distancia_dezena(distancia_dezena), .distancia_unidade(distancia_unidade),
    .tx_pronto(tx_pronto), .tx_partida(t_partida), .tx_dados(t_dados),
    .envio_pronto(t_envio), .erro(t_erro), .ocupado(t_ocupado),
    .db_estado(t_db)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] ac, ad, au, dc, dd, du);
    angulo_centena    = ac;
    angulo_dezena     = ad;
    angulo_unidade    = au;
    distancia_centena = dc;
    distancia_dezena  = dd;
    distancia_unidade = du;
  endtask

  // Starts a frame at c=0 and answers each tx_partida with tx_pronto dly cycles later.
  // noise: extra transmitir pulses and digit changes while busy.
  // rst_at: cycle at which reset is pulsed to cut the frame short (-1 = never).
  task automatic run_frame(input int dly, input bit noise, input int rst_at, input int budget);
    int cd;
    cd = -1;
    nchars = 0; nenv = 0; nerr = 0; env_cyc = -1; done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      transmitir = (c == 0) || (noise && (c % 7 == 3));
      if (noise && c == 5) set_digits(4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9);
      if (tx_partida) begin
        if (nchars < 8) begin
          chars[nchars]    = tx_dados;
          part_cyc[nchars] = c;
        end
        nchars++;
        cd = dly;
      end
      tx_pronto = (cd == 0);
      if (cd >= 0) cd--;
      if (envio_pronto) begin
        nenv++;
        env_cyc = c;
      end
      if (erro) nerr++;
      if (envio_pronto || erro) begin
        done = 1'b1;
        break;
      end
      if (c == rst_at) begin
        transmitir = 1'b0;
        tx_pronto  = 1'b0;
        reset      = 1'b1;
        step();
        reset = 1'b0;
        done  = 1'b1;
        break;
      end
      step();
    end
    transmitir = 1'b0;
    tx_pronto  = 1'b0;
  endtask

  initial begin
    logic [6:0] exp_a [8];
    logic [6:0] exp_b [8];
    int pulses;
    exp_a = '{7'h30, 7'h39, 7'h30, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23};
    exp_b = '{7'h31, 7'h38, 7'h30, 7'h2C, 7'h3F, 7'h35, 7'h37, 7'h23};

    reset = 1'b1;
    transmitir = 1'b0;
    tx_pronto = 1'b0;
    set_digits(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
    step();
    step();
    check_val("rst_db_estado", db_estado, 4'h0);
    check_val("rst_ocupado", ocupado, 1'b0);
    check_val("rst_tx_dados", tx_dados, 7'h30);
    check_val("rst_tx_partida", tx_partida, 1'b0);
    check_val("rst_envio_pronto", envio_pronto, 1'b0);
    check_val("rst_erro", erro, 1'b0);
    reset = 1'b0;
    step();

    // tx_pronto while idle must not move the FSM
    tx_pronto = 1'b1;
    step();
    tx_pronto = 1'b0;
    check_val("idle_pronto_db", db_estado, 4'h0);
    check_val("idle_pronto_ocupado", ocupado, 1'b0);
    step();

    // Basic frame, tx_pronto 20 cycles after each tx_partida
    set_digits(4'h0, 4'h9, 4'h0, 4'h1, 4'h2, 4'h3);
    run_frame(20, 1'b0, -1, 400);
    check_val("f1_done", done, 1'b1);
    check_val("f1_nchars", nchars, 8);
    check_val("f1_nenv", nenv, 1);
    check_val("f1_nerr", nerr, 0);
    check_val("f1_ocupado_fim", ocupado, 1'b1);
    for (int i = 0; i < 8; i++) check_val($sformatf("f1_char%0d", i), chars[i], exp_a[i]);
    step();
    check_val("f1_idle_db", db_estado, 4'h0);
    check_val("f1_idle_ocupado", ocupado, 1'b0);

    // Latency: tx_partida at 2, tx_pronto at 10 -> next tx_partida at 13
    run_frame(8, 1'b0, -1, 200);
    check_val("lat_first_partida", part_cyc[0], 2);
    check_val("lat_second_partida", part_cyc[1], 13);
    check_val("lat_last_partida", part_cyc[7], 79);
    check_val("lat_envio", env_cyc, 89);
    step();

    // Invalid digit, mid-frame digit changes and extra transmitir pulses
    set_digits(4'h1, 4'h8, 4'h0, 4'hC, 4'h5, 4'h7);
    run_frame(3, 1'b1, -1, 200);
    check_val("nz_done", done, 1'b1);
    check_val("nz_nchars", nchars, 8);
    check_val("nz_nenv", nenv, 1);
    for (int i = 0; i < 8; i++) check_val($sformatf("nz_char%0d", i), chars[i], exp_b[i]);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tx_partida) pulses++;
    end
    check_val("nz_no_second_frame", pulses, 0);

    // Reset during ESPERA of character 5
    set_digits(4'h0, 4'h9, 4'h0, 4'h1, 4'h2, 4'h3);
    run_frame(4, 1'b0, 39, 200);
    check_val("mr_nchars", nchars, 6);
    check_val("mr_nenv", nenv, 0);
    check_val("mr_db", db_estado, 4'h0);
    check_val("mr_ocupado", ocupado, 1'b0);
    check_val("mr_tx_dados", tx_dados, 7'h30);
    check_val("mr_partida", tx_partida, 1'b0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_partida || envio_pronto || erro) pulses++;
      step();
    end
    check_val("mr_no_pulses", pulses, 0);
    run_frame(4, 1'b0, -1, 200);
    check_val("mr_new_nenv", nenv, 1);
    check_val("mr_new_nchars", nchars, 8);
    check_val("mr_new_char0", chars[0], 7'h30);
    check_val("mr_new_char7", chars[7], 7'h23);

    // Timeout on the TIMEOUT_CICLOS=16 instance: ESPERA spans cycles 3..18
    reset = 1'b1;
    step();
    reset = 1'b0;
    transmitir = 1'b1;
    step();
    transmitir = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check_val("to_last_wait_db", t_db, 4'h3);
    check_val("to_last_wait_erro", t_erro, 1'b0);
    step();
    check_val("to_erro", t_erro, 1'b1);
    check_val("to_db_erro", t_db, 4'hF);
    check_val("to_no_envio", t_envio, 1'b0);
    step();
    check_val("to_back_db", t_db, 4'h0);
    check_val("to_back_ocupado", t_ocupado, 1'b0);
    check_val("to_erro_one_cycle", t_erro, 1'b0);

    // tx_pronto on the final timeout cycle wins
    reset = 1'b1;
    step();
    reset = 1'b0;
    transmitir = 1'b1;
    step();
    transmitir = 1'b0;
    for (int i = 0; i < 17; i++) step();
    tx_pronto = 1'b1;
    step();
    tx_pronto = 1'b0;
    check_val("race_db_proximo", t_db, 4'h4);
    check_val("race_no_erro", t_erro, 1'b0);
    step();
    check_val("race_db_prepara", t_db, 4'h1);
    check_val("race_no_erro2", t_erro, 1'b0);

    reset = 1'b1;
    step();
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
